ppa_seq_adder: RTL and testbench
================================

# ppa_seq_adder

Nibble-serial wide-adder sequencer. It shares the 4-bit prefix adder (`adder`) between `NREQ` requesters and evaluates one `WIDTH`-bit addition per transaction by stepping the 4-bit slice LSB-first. A registered carry links each step to the next. It sits between requester-side valid/ready channels and a single response channel, so the small adder can serve wide operands.

## Interface
Parameters:
- `WIDTH`, 16: operand width in bits; must be a multiple of 4 and at least 4.
- `NREQ`, 2: number of requesters, at least 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NREQ  request valid, one bit per requester.
- `req_ready`  out  NREQ  request accepted; at most one bit is set.
- `req_a`  in  NREQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH].
- `req_b`  in  NREQ*WIDTH  operand B, same packing as `req_a`.
- `req_cin`  in  NREQ  carry-in, one bit per requester.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  result consumed.
- `rsp_id`  out  $clog2(NREQ) (min 1)  index of the requester that issued the result.
- `rsp_sum`  out  WIDTH  sum.
- `rsp_cout`  out  1  carry-out of bit WIDTH-1.
- `rsp_ovf`  out  1  signed overflow; present only with `PPA_SEQ_OVF_EN`.

## Operation
- NNIB = WIDTH/4. The FSM has three states: IDLE, RUN, RESP.
- **IDLE**
  - The round-robin arbiter searches upward from pointer `rr` and picks the first requester with `req_valid` set.
  - `req_ready[g]` is asserted combinationally, in the same cycle, for the granted requester only.
  - On handshake: latch A, B, id = g, carry = `req_cin[g]`; set nib = 0; set `rr` = (g+1) mod NREQ; go to RUN.
  - If no requester is valid: stay in IDLE and leave `rr` unchanged.
- **RUN**
  - Each cycle, drive the adder with a = A[nib*4 +: 4], b = B[nib*4 +: 4], cin = carry.
  - Register sum into result[nib*4 +: 4], set carry to the adder cout, then increment nib.
  - After the step with nib == NNIB-1, go to RESP.
- **RESP**
  - `rsp_valid` = 1. `rsp_sum`, `rsp_cout`, `rsp_id` and `rsp_ovf` are held stable.
  - On `rsp_valid && rsp_ready`, go to IDLE.
- `req_ready` is 0 in both RUN and RESP. One transaction is in flight at most.
- Arithmetic is unsigned modulo 2^WIDTH. `rsp_cout` = final registered carry.
- `req_valid` deasserting on a non-granted requester has no effect. A request that has not been granted carries no state.
- Reset is asynchronous at any time, including mid-RUN or in RESP. It sets FSM = IDLE, `rr` = 0, nib = 0 and carry = 0, and clears all registered result fields. The in-flight operation is dropped; no response is issued for it.
- Reset values of outputs: `req_ready` = 0 (combinational; zero while `rst_n` is low), `rsp_valid` = 0, `rsp_id` = 0, `rsp_sum` = 0, `rsp_cout` = 0, `rsp_ovf` = 0.

## Timing
- Handshake in cycle t.
- RUN occupies cycles t+1 through t+NNIB.
- `rsp_valid` is high from cycle t+NNIB+1.
- With `rsp_ready` held high, the block is back in IDLE at t+NNIB+2, and the next handshake can occur in that cycle.
- Throughput is one operation per NNIB+2 cycles. For WIDTH=16 that is a latency of 5 cycles to `rsp_valid` and 6 cycles per operation.
- The adder is used purely combinationally inside one RUN cycle. There is no multicycle path.

## Configuration
- `PPA_SEQ_OVF_EN` defined:
  - `rsp_ovf` port exists.
  - Value: ovf = c_in(WIDTH-1) XOR cout, where c_in(WIDTH-1) = A[W-1] ^ B[W-1] ^ sum[W-1].
  - Registered at the final RUN step.
- `PPA_SEQ_OVF_EN` undefined:
  - Port absent, with no overflow logic.
  - All other behaviour is identical.

## Structure
- Shared package `ppa_seq_pkg` holds:
  - `NIB_W` = 4.
  - The state enum `ppa_seq_state_t`: IDLE, RUN, RESP.
  - A function that returns the id width as max(1, clog2(n)).
- One sub-module: `ppa_rr_arb`, the NREQ-way round-robin arbiter.
  - Inputs: request vector, pointer, enable.
  - Outputs: one-hot grant and the encoded index.
- The existing `adder` is instantiated once as the datapath slice.

## Test plan
Default parameters (WIDTH=16, NREQ=2) unless noted.
- **Carry ripple across all nibbles:** req0 sends A=0xFFFF, B=0x0001, cin=0. Expect `rsp_sum`=0x0000, `rsp_cout`=1, `rsp_id`=0, with `rsp_valid` first high 5 cycles after the handshake.
- **Carry-in:** req1 sends A=0x1234, B=0x4321, cin=1. Expect 0x5556, cout=0, `rsp_id`=1.
- **Arbitration fairness:** after reset, both requesters hold valid continuously with distinct operands.
  - Grants go 0, 1, 0, 1.
  - Never both `req_ready` bits in one cycle.
  - Operations start 6 cycles apart.
- **Response backpressure:** hold `rsp_ready`=0 for 4 cycles in RESP.
  - `rsp_valid` stays 1 and all `rsp_*` fields are stable.
  - `req_ready` stays 0.
  - Completion in the cycle after `rsp_ready` rises.
- **Reset mid-operation:** assert `rst_n`=0 in the second RUN cycle.
  - All outputs go to 0 immediately and no response is issued.
  - The next request, A=0x00FF, B=0x0F01, returns 0x1000, cout=0.
- **Overflow (with `PPA_SEQ_OVF_EN` defined):**
  - 0x7FFF+0x0001 gives `rsp_ovf`=1, cout=0.
  - 0xFFFF+0x0001 gives `rsp_ovf`=0, cout=1.

Source files
------------

// File: rtl/ppa_seq_pkg.sv
// Shared definitions for the nibble-serial wide-adder sequencer.
package ppa_seq_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RESP
    } ppa_seq_state_t;

    // Index width that stays at least one bit wide for a single requester.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder.sv
// 4-bit parallel-prefix adder slice (Kogge-Stone style carry tree with carry-in).
module adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic       g0c;
    logic       g1_l1;
    logic       g2_l1;
    logic       p2_l1;
    logic       g3_l1;
    logic       p3_l1;
    logic [4:1] c;

    assign g = a & b;
    assign p = a ^ b;

    // Carry-in folded into bit 0 so the tree treats it as a generate.
    assign g0c   = g[0] | (p[0] & cin);
    assign g1_l1 = g[1] | (p[1] & g0c);
    assign g2_l1 = g[2] | (p[2] & g[1]);
    assign p2_l1 = p[2] & p[1];
    assign g3_l1 = g[3] | (p[3] & g[2]);
    assign p3_l1 = p[3] & p[2];

    assign c[1] = g0c;
    assign c[2] = g1_l1;
    assign c[3] = g2_l1 | (p2_l1 & g0c);
    assign c[4] = g3_l1 | (p3_l1 & g1_l1);

    assign sum  = p ^ {c[3:1], cin};
    assign cout = c[4];

endmodule

// File: rtl/ppa_rr_arb.sv
// NREQ-way round-robin arbiter: first requester at or above ptr (wrapping) wins.
module ppa_rr_arb #(
    parameter int NREQ = 2,
    parameter int ID_W = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] idx
);

    logic found;

    function automatic int wrap(input int base, input int step);
        return (base + step) % NREQ;
    endfunction

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (en && !found && req[wrap(int'(ptr), k)]) begin
                grant[wrap(int'(ptr), k)] = 1'b1;
                idx                       = ID_W'(wrap(int'(ptr), k));
                found                     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ppa_seq_adder.sv
// Nibble-serial wide adder shared by NREQ requesters through one 4-bit slice.
// Optional signed-overflow output rsp_ovf is built when PPA_SEQ_OVF_EN is defined.
module ppa_seq_adder
    import ppa_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREQ  = 2,
    localparam int ID_W = id_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
`ifdef PPA_SEQ_OVF_EN
    output logic                  rsp_ovf,
`endif
    output logic                  rsp_cout
);

    localparam int NNIB      = WIDTH / NIB_W;
    localparam int NIB_CNT_W = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam logic [NIB_CNT_W-1:0] LAST_NIB = NIB_CNT_W'(NNIB - 1);
    localparam logic [ID_W-1:0]      LAST_ID  = ID_W'(NREQ - 1);

    ppa_seq_state_t state_q;
    ppa_seq_state_t state_d;

    logic [ID_W-1:0]      rr_q;
    logic [ID_W-1:0]      id_q;
    logic [ID_W-1:0]      grant_idx;
    logic [NREQ-1:0]      grant;
    logic                 arb_en;
    logic                 accept;
    logic                 last_step;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     result_q;
    logic                 carry_q;
    logic [NIB_CNT_W-1:0] nib_q;
    logic [NIB_W-1:0]     slice_a;
    logic [NIB_W-1:0]     slice_b;
    logic [NIB_W-1:0]     slice_sum;
    logic                 slice_cout;

    ppa_rr_arb #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_q),
        .en    (arb_en),
        .grant (grant),
        .idx   (grant_idx)
    );

    assign slice_a = a_q[nib_q*NIB_W +: NIB_W];
    assign slice_b = b_q[nib_q*NIB_W +: NIB_W];

    adder u_adder (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    assign req_ready = grant;
    assign accept    = |grant;
    assign last_step = (state_q == RUN) && (nib_q == LAST_NIB);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave a latch.
        state_d   = state_q;
        arb_en    = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated by rst_n so req_ready reads 0 for the whole reset pulse.
                arb_en = rst_n;
                if (accept) state_d = RUN;
            end
            RUN: begin
                if (last_step) state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the operand and result registers are reset too, so every rsp_* field reads 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            nib_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments here, so every register samples pre-edge values.
            state_q <= state_d;
            if (accept) begin
                a_q     <= req_a[grant_idx*WIDTH +: WIDTH];
                b_q     <= req_b[grant_idx*WIDTH +: WIDTH];
                id_q    <= grant_idx;
                carry_q <= req_cin[grant_idx];
                nib_q   <= '0;
                rr_q    <= (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
            end else if (state_q == RUN) begin
                result_q[nib_q*NIB_W +: NIB_W] <= slice_sum;
                carry_q                        <= slice_cout;
                nib_q                          <= last_step ? '0 : nib_q + 1'b1;
            end
        end
    end

`ifdef PPA_SEQ_OVF_EN
    logic ovf_q;

    // Carry into the sign bit is recovered from A, B and the sum bit, then XORed with cout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (last_step) begin
            ovf_q <= a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice_sum[NIB_W-1] ^ slice_cout;
        end
    end

    assign rsp_ovf = ovf_q;
`endif

    assign rsp_id   = id_q;
    assign rsp_sum  = result_q;
    assign rsp_cout = carry_q;

endmodule

// File: tb/tb_ppa_seq_adder.sv
// Randomized self-checking bench for ppa_seq_adder against a plain-arithmetic reference.
module tb_ppa_seq_adder;

    localparam int WIDTH = 16;
    localparam int NREQ  = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_cin;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [0:0]            rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;
`ifdef PPA_SEQ_OVF_EN
    logic                  rsp_ovf;
`endif

    int total    = 0;
    int bad      = 0;
    int cyc      = 0;
    int rr_model = 0;

    logic [WIDTH-1:0] opa [NREQ];
    logic [WIDTH-1:0] opb [NREQ];
    logic             opc [NREQ];

    ppa_seq_adder #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
`ifdef PPA_SEQ_OVF_EN
        .rsp_ovf   (rsp_ovf),
`endif
        .rsp_cout  (rsp_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = opa[i];
            req_b[i*WIDTH +: WIDTH] = opb[i];
            req_cin[i]              = opc[i];
        end
    endtask

    task automatic randomize_ops(input int i);
        opa[i] = WIDTH'($urandom);
        opb[i] = WIDTH'($urandom);
        opc[i] = 1'($urandom);
    endtask

    function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic c);
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    endfunction

    function automatic int ref_pick(input logic [NREQ-1:0] mask, input int rr);
        for (int k = 0; k < NREQ; k++) begin
            if (mask[(rr + k) % NREQ]) return (rr + k) % NREQ;
        end
        return 0;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_id"}, rsp_id, 0);
        check({tag, "_rsp_sum"}, rsp_sum, 0);
        check({tag, "_rsp_cout"}, rsp_cout, 0);
`ifdef PPA_SEQ_OVF_EN
        check({tag, "_rsp_ovf"}, rsp_ovf, 0);
`endif
    endtask

    // One full transaction; keep leaves the winner valid with fresh operands afterwards.
    task automatic do_op(input logic [NREQ-1:0] mask, input int stall, input bit keep, output int start);
        int g;
        int t0;
        int k;
        int busy_ready;
        logic [WIDTH:0] full;
        logic exp_ovf;

        start     = -1;
        rsp_ready = (stall == 0);
        drive_ops();
        req_valid = mask;
        #1;
        k = 0;
        while (req_ready == '0 && k < 20) begin
            step();
            k++;
        end
        g = ref_pick(mask, rr_model);
        check("grant", req_ready, NREQ'(1) << g);
        if (req_ready == '0) begin
            req_valid = '0;
            return;
        end

        rr_model = (g + 1) % NREQ;
        full     = ref_add(opa[g], opb[g], opc[g]);
        exp_ovf  = (opa[g][WIDTH-1] == opb[g][WIDTH-1]) && (full[WIDTH-1] != opa[g][WIDTH-1]);
        t0       = cyc;
        start    = t0;

        step();
        if (keep) begin
            randomize_ops(g);
            drive_ops();
        end else begin
            req_valid[g] = 1'b0;
        end
        #1;

        busy_ready = 0;
        k = 0;
        while (!rsp_valid && k < 20) begin
            if (req_ready != '0) busy_ready++;
            step();
            k++;
        end
        check("ready_during_run", busy_ready, 0);
        check("latency", cyc - t0, 5);

        for (int s = 0; s <= stall; s++) begin
            check("rsp_valid", rsp_valid, 1);
            check("rsp_sum", rsp_sum, full[WIDTH-1:0]);
            check("rsp_cout", rsp_cout, full[WIDTH]);
            check("rsp_id", rsp_id, g);
`ifdef PPA_SEQ_OVF_EN
            check("rsp_ovf", rsp_ovf, exp_ovf);
`endif
            check("ready_in_resp", req_ready, 0);
            if (s == stall) rsp_ready = 1'b1;
            step();
        end
        check("rsp_done", rsp_valid, 0);
    endtask

    initial begin
        int st;
        int prev;
        int seen;

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = '0;
            opb[i] = '0;
            opc[i] = 1'b0;
        end
        #1;
        check_idle_outputs("reset");
        step();
        step();
        rst_n = 1'b1;
        step();

        // Carry ripple through every nibble.
        opa[0] = 16'hFFFF; opb[0] = 16'h0001; opc[0] = 1'b0;
        do_op(2'b01, 0, 1'b0, st);
        // Carry-in from requester 1.
        opa[1] = 16'h1234; opb[1] = 16'h4321; opc[1] = 1'b1;
        do_op(2'b10, 0, 1'b0, st);

        // Both requesters valid: alternating grants, back-to-back every 6 cycles.
        randomize_ops(0);
        randomize_ops(1);
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            do_op(2'b11, 0, 1'b1, st);
            if (prev >= 0) check("spacing", st - prev, 6);
            prev = st;
        end
        req_valid = '0;
        step();

        // Response backpressure with the other requester still pending.
        do_op(2'b11, 4, 1'b1, st);
        req_valid = '0;
        step();

        // Reset in the second RUN cycle drops the operation.
        opa[0] = 16'h1111; opb[0] = 16'h2222; opc[0] = 1'b0;
        drive_ops();
        req_valid = 2'b01;
        #1;
        check("rst_grant", req_ready, 2'b01);
        step();
        step();
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrun_reset");
        step();
        check("reset_hold_ready", req_ready, 0);
        req_valid = '0;
        rst_n     = 1'b1;
        rr_model  = 0;
        seen      = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (rsp_valid) seen++;
        end
        check("no_rsp_after_reset", seen, 0);
        opa[0] = 16'h00FF; opb[0] = 16'h0F01; opc[0] = 1'b0;
        do_op(2'b01, 0, 1'b0, st);

`ifdef PPA_SEQ_OVF_EN
        opa[0] = 16'h7FFF; opb[0] = 16'h0001; opc[0] = 1'b0;
        do_op(2'b01, 0, 1'b0, st);
        opa[0] = 16'hFFFF; opb[0] = 16'h0001; opc[0] = 1'b0;
        do_op(2'b01, 0, 1'b0, st);
`endif

        // Random mix of masks, operands and response stalls.
        for (int i = 0; i < 16; i++) begin
            randomize_ops(0);
            randomize_ops(1);
            do_op(NREQ'($urandom_range(1, 3)), $urandom_range(0, 2), 1'b0, st);
            req_valid = '0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
